// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: machine word, fetch FSM states,
// word-alignment mask and the helper that applies it.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      VALID  = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   // Instruction addresses are word aligned; the low two bits are dropped.
   function automatic word_t align_word(input word_t addr);
      return addr & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: icache read port, decode handshake and the
// execute-stage redirect/halt controls. The master side is the fetch unit.
interface instr_fetch_unit_if;
   import cpu_types_pkg::*;

   logic  iREN;
   word_t iaddr;
   logic  ihit;
   word_t iload;
   word_t instr;
   logic  instr_valid;
   logic  instr_ready;
   word_t pc;
   word_t pc_plus4;
   logic  redirect;
   word_t redirect_pc;
   logic  halt;

   modport master (
      output iREN, iaddr, instr, instr_valid, pc, pc_plus4,
      input  ihit, iload, instr_ready, redirect, redirect_pc, halt
   );

   modport slave (
      input  iREN, iaddr, instr, instr_valid, pc, pc_plus4,
      output ihit, iload, instr_ready, redirect, redirect_pc, halt
   );

endinterface

// File: rtl/sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
// clr has priority over en.
module sat_counter
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  clr,
   input  logic  en,
   output word_t count
);

   // Count enabled events, holding at the maximum value.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count <= 32'h0000_0000;
      end else if (clr) begin
         count <= 32'h0000_0000;
      end else if (en && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one icache read at a time,
// latches the returned word and hands it to decode on valid/ready.
// Execute can redirect the PC; a HALT delivered to decode stops fetch
// until reset. Optional performance counters are built when the macro
// FETCH_PERF_EN is defined; otherwise both counter ports read zero.
module instr_fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
) (
   input  logic               CLK,
   input  logic               nRST,
   instr_fetch_unit_if.master bus,
   output logic               halted,
   output word_t              fetch_count,
   output word_t              wait_count
);

   fetch_state_t state;
   word_t        cur_pc;
   word_t        instr_word;

   // Fetch FSM: PC update, instruction latch and state sequencing.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= FETCH;
         cur_pc     <= PC_INIT;
         instr_word <= 32'h0000_0000;
      end else begin
         case (state)
            FETCH: begin
               // A redirect wins over a same-cycle hit; that data is stale.
               if (bus.redirect) begin
                  cur_pc <= align_word(bus.redirect_pc);
               end else if (bus.ihit) begin
                  instr_word <= bus.iload;
                  state      <= VALID;
               end else begin
                  state <= FETCH;
               end
            end
            VALID: begin
               if (bus.instr_ready && bus.halt) begin
                  state <= HALTED;
               end else if (bus.redirect) begin
                  // Covers both a consumed word and a dropped one.
                  cur_pc <= align_word(bus.redirect_pc);
                  state  <= FETCH;
               end else if (bus.instr_ready) begin
                  cur_pc <= cur_pc + 32'd4;
                  state  <= FETCH;
               end else begin
                  state <= VALID;
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

   assign bus.iREN        = (state == FETCH) & nRST;
   assign bus.iaddr       = cur_pc;
   assign bus.pc          = cur_pc;
   assign bus.pc_plus4    = cur_pc + 32'd4;
   assign bus.instr       = instr_word;
   assign bus.instr_valid = (state == VALID);
   assign halted          = (state == HALTED);

`ifdef FETCH_PERF_EN
   logic fetch_event;
   logic wait_event;

   // Neither event can occur in HALTED, so both counters freeze there.
   assign fetch_event = (state == VALID) & bus.instr_ready;
   assign wait_event  = (state == FETCH) & ~bus.ihit;

   sat_counter u_fetch_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .clr   (1'b0),
      .en    (fetch_event),
      .count (fetch_count)
   );

   sat_counter u_wait_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .clr   (1'b0),
      .en    (wait_event),
      .count (wait_count)
   );
`else
   assign fetch_count = 32'h0000_0000;
   assign wait_count  = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a
// behavioural model of the fetch/deliver/redirect/halt rules.
module tb_instr_fetch_unit;

   localparam logic [31:0] P_INIT = 32'h0000_0000;

   logic        CLK;
   logic        nRST;
   logic        halted;
   logic [31:0] fetch_count;
   logic [31:0] wait_count;

   int checks   = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(.PC_INIT(P_INIT)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .bus         (bus),
      .halted      (halted),
      .fetch_count (fetch_count),
      .wait_count  (wait_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc, m_word, m_fc, m_wc;
   logic        m_have, m_stop;

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_pc <= P_INIT; m_word <= 32'd0; m_have <= 1'b0; m_stop <= 1'b0;
         m_fc <= 32'd0;  m_wc <= 32'd0;
      end else if (!m_stop) begin
         if (!m_have) begin
            if (!bus.ihit && m_wc != 32'hFFFF_FFFF) m_wc <= m_wc + 32'd1;
            if (bus.redirect) m_pc <= {bus.redirect_pc[31:2], 2'b00};
            else if (bus.ihit) begin
               m_word <= bus.iload;
               m_have <= 1'b1;
            end
         end else if (bus.instr_ready) begin
            if (m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 32'd1;
            m_have <= 1'b0;
            if (bus.halt) m_stop <= 1'b1;
            else if (bus.redirect) m_pc <= {bus.redirect_pc[31:2], 2'b00};
            else m_pc <= m_pc + 32'd4;
         end else if (bus.redirect) begin
            m_have <= 1'b0;
            m_pc   <= {bus.redirect_pc[31:2], 2'b00};
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge CLK) begin
      if (chk_en) begin
         check("iREN",        32'(bus.iREN),        32'(nRST & ~m_have & ~m_stop));
         check("iaddr",       bus.iaddr,            m_pc);
         check("pc",          bus.pc,               m_pc);
         check("pc_plus4",    bus.pc_plus4,         m_pc + 32'd4);
         check("instr_valid", 32'(bus.instr_valid), 32'(m_have));
         check("halted",      32'(halted),          32'(m_stop));
         if (m_have) check("instr", bus.instr, m_word);
`ifdef FETCH_PERF_EN
         check("fetch_count", fetch_count, m_fc);
         check("wait_count",  wait_count,  m_wc);
`else
         check("fetch_count", fetch_count, 32'd0);
         check("wait_count",  wait_count,  32'd0);
`endif
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ihit = 1'b0; bus.iload = 32'd0; bus.instr_ready = 1'b0;
      bus.redirect = 1'b0; bus.redirect_pc = 32'd0; bus.halt = 1'b0;
   endtask

   logic [31:0] save_pc;
   bit          got;

   initial begin
      nRST = 1'b0;
      idle_inputs();
      tick();
      tick();
      // 1: reset state
      check("rst_iREN",  32'(bus.iREN), 32'd0);
      check("rst_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_instr", bus.instr, 32'd0);
      check("rst_pc",    bus.pc, 32'h0000_0000);
      chk_en = 1'b1;
      nRST = 1'b1;
      #1;
      check("post_rst_iREN", 32'(bus.iREN), 32'd1);
      tick();                                   // miss cycle
      bus.ihit = 1'b1; bus.iload = 32'h2001_0005;
      tick();                                   // hit captured
      bus.ihit = 1'b0;
      check("t1_valid", 32'(bus.instr_valid), 32'd1);
      check("t1_instr", bus.instr, 32'h2001_0005);
      check("t1_pc",    bus.pc, 32'h0000_0000);
      // 2: hold without ready, then consume
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_hold_instr", bus.instr, 32'h2001_0005);
         check("t2_hold_pc",    bus.pc, 32'h0000_0000);
      end
      bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
      check("t2_iREN",  32'(bus.iREN), 32'd1);
      check("t2_iaddr", bus.iaddr, 32'h0000_0004);
      // 3: redirect beats same-cycle hit
      bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
      bus.ihit = 1'b1; bus.iload = 32'hDEAD_BEEF;
      tick();
      idle_inputs();
      check("t3_pc",    bus.pc, 32'h0000_0100);
      check("t3_valid", 32'(bus.instr_valid), 32'd0);
      check("t3_iREN",  32'(bus.iREN), 32'd1);
      // 4: PC wrap
      bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
      tick();
      idle_inputs();
      bus.ihit = 1'b1; bus.iload = 32'h1234_5678;
      tick();
      idle_inputs();
      check("t4_pc",       bus.pc, 32'hFFFF_FFFC);
      check("t4_pc_plus4", bus.pc_plus4, 32'h0000_0000);
      bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
      check("t4_wrap_pc", bus.pc, 32'h0000_0000);
      // randomized traffic (halt only offered without ready)
      for (int i = 0; i < 600; i++) begin
         bus.ihit        = ($urandom_range(0, 1) == 1);
         bus.iload       = $urandom;
         bus.instr_ready = ($urandom_range(0, 9) < 6);
         bus.redirect    = ($urandom_range(0, 9) < 2);
         bus.redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                                        : $urandom;
         bus.halt        = bus.instr_ready ? 1'b0 : ($urandom_range(0, 1) == 1);
         tick();
      end
      // 5: halt
      idle_inputs();
      bus.ihit = 1'b1; bus.iload = 32'hA5A5_0001;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         got = bus.instr_valid;
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL t5_reach_valid actual=timeout expected=instr_valid");
      end
      idle_inputs();
      save_pc = m_pc;
      bus.halt = 1'b1; bus.instr_ready = 1'b1;
      tick();
      idle_inputs();
      check("t5_halted", 32'(halted), 32'd1);
      check("t5_iREN",   32'(bus.iREN), 32'd0);
      check("t5_valid",  32'(bus.instr_valid), 32'd0);
      for (int i = 0; i < 6; i++) begin
         bus.ihit = 1'b1; bus.redirect = i[0]; bus.redirect_pc = 32'h0000_0400;
         bus.instr_ready = 1'b1; bus.halt = i[1];
         tick();
         check("t5_still_halted", 32'(halted), 32'd1);
         check("t5_still_iREN",   32'(bus.iREN), 32'd0);
         check("t5_pc_frozen",    bus.pc, save_pc);
      end
      idle_inputs();
      nRST = 1'b0;
      #1;
      check("t5_rst_pc",     bus.pc, P_INIT);
      check("t5_rst_halted", 32'(halted), 32'd0);
      check("t5_rst_iREN",   32'(bus.iREN), 32'd0);
      tick();
      // 6: counters, 3 instrs with 2 miss cycles each
      nRST = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         tick();
         bus.ihit = 1'b1; bus.iload = $urandom;
         tick();
         bus.ihit = 1'b0; bus.instr_ready = 1'b1;
         tick();
         bus.instr_ready = 1'b0;
      end
`ifdef FETCH_PERF_EN
      check("t6_fetch_count", fetch_count, 32'd3);
      check("t6_wait_count",  wait_count,  32'd6);
`else
      check("t6_fetch_count", fetch_count, 32'd0);
      check("t6_wait_count",  wait_count,  32'd0);
`endif
      tick();
      tick();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
